// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
//
// Shared definitions for the UART transmitter arbiter:
//   arb_state_e          - FSM state encoding (header states are always encoded,
//                          they are only reachable when UART_ARB_HDR_EN is defined)
//   HDR_TAG              - upper nibble of the optional per-byte header
//   ACK_TIMEOUT_DEFAULT  - default ack timeout in clk cycles
//   TO_CNT_W             - width of the ack timeout counter
package uart_arb_pkg;

    typedef enum logic [2:0] {
        ST_ARB       = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_HDR_SEND  = 3'd3,
        ST_HDR_WAIT  = 3'd4
    } arb_state_e;

    localparam logic [3:0]  HDR_TAG             = 4'hA;
    localparam int unsigned ACK_TIMEOUT_DEFAULT = 4096;
    localparam int unsigned TO_CNT_W            = 16;

endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker
//
// Combinational round-robin picker. The search starts one position after
// last_i (wrapping modulo N_REQ) and grants the first requester found valid.
//
// Ports:
//   req_valid_i  in  N_REQ           request vector
//   last_i       in  clog2(N_REQ)    index of the previously granted requester
//   grant_o      out N_REQ           one-hot grant, all zero when nothing is valid
//   any_o        out 1               at least one requester is valid
module uart_rr_picker #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [$clog2(N_REQ)-1:0] last_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     any_o
);

    localparam int unsigned IDW = $clog2(N_REQ);

    logic            found;
    logic [IDW-1:0]  idx;
    int unsigned     pos;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        pos     = 0;
        // k = N_REQ wraps back onto last_i itself, so a lone requester that
        // was served last is still picked again.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            pos = 32'(last_i) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            idx = IDW'(pos);
            if (!found && req_valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign any_o = |req_valid_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one UART transmitter among N_REQ byte-stream requesters using
// round-robin arbitration. One byte is taken from the winner, presented to
// the transmitter with tx_start held until tx_busy acknowledges it, and the
// frame is tracked until tx_busy falls. A missing ack within ACK_TIMEOUT
// cycles drops the byte and pulses err_timeout.
//
// Optional feature macro: UART_ARB_HDR_EN -- when defined, every payload byte
// is preceded by a header byte {HDR_TAG, grant_id}.
//
// Handshake: req_ready[i] is high (combinationally, only in ARB) in the cycle
// the byte on req_data[8i+:8] is accepted; acceptance happens at the rising
// edge where req_valid[i] && req_ready[i]. A requester keeps req_valid and
// req_data stable until it sees req_ready.
//
// Ports:
//   clk          in   1             system clock
//   rst          in   1             asynchronous active-low reset
//   req_valid    in   N_REQ         per-requester byte available
//   req_data     in   8*N_REQ       flat byte bus, requester i on [8i+7:8i]
//   req_ready    out  N_REQ         one-hot acceptance strobe
//   tx_data      out  8             byte to the transmitter
//   tx_start     out  1             transmit request, held until tx_busy
//   tx_busy      in   1             transmitter busy
//   grant_id     out  clog2(N_REQ)  current / last granted requester
//   active       out  1             FSM not in ARB
//   err_timeout  out  1             one-cycle pulse on a dropped byte
//   dbg_state    out  arb_state_e   current FSM state
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     active,
    output logic                     err_timeout,
    output arb_state_e               dbg_state
);

    localparam int unsigned         IDW     = $clog2(N_REQ);
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(ACK_TIMEOUT - 1);

    arb_state_e          state_q, state_d;
    logic [IDW-1:0]      last_q,  last_d;
    logic [IDW-1:0]      grant_q, grant_d;
    logic [7:0]          hold_q,  hold_d;
    logic [TO_CNT_W-1:0] cnt_q,   cnt_d;
    logic                err_q,   err_d;

    logic [N_REQ-1:0]    pick;
    logic                pick_any;
    logic [IDW-1:0]      pick_id;
    logic [N_REQ-1:0]    ready_c;

    uart_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req_valid_i (req_valid),
        .last_i      (last_q),
        .grant_o     (pick),
        .any_o       (pick_any)
    );

    always_comb begin
        pick_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                pick_id = IDW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        ready_c = '0;

        case (state_q)
            ST_ARB: begin
                if (pick_any) begin
                    ready_c = pick;
                    last_d  = pick_id;
                    grant_d = pick_id;
                    hold_d  = req_data[8*pick_id +: 8];
                    cnt_d   = '0;
`ifdef UART_ARB_HDR_EN
                    state_d = ST_HDR_SEND;
`else
                    state_d = ST_SEND;
`endif
                end
            end

            // The transmitter only samples tx_start on baud ticks, so the
            // request stays up until tx_busy is seen, bounded by the timeout.
            ST_SEND: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_ARB;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_ARB;
                end
            end

`ifdef UART_ARB_HDR_EN
            // A header timeout returns straight to ARB, dropping the payload.
            ST_HDR_SEND: begin
                if (tx_busy) begin
                    state_d = ST_HDR_WAIT;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_ARB;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_HDR_WAIT: begin
                if (!tx_busy) begin
                    state_d = ST_SEND;
                    cnt_d   = '0;
                end
            end
`endif

            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ARB;
            last_q  <= IDW'(N_REQ - 1);
            grant_q <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // The state register already sits in ARB while reset is held, so the
    // combinational ready is masked to keep req_ready low during reset.
    assign req_ready = rst ? ready_c : '0;

`ifdef UART_ARB_HDR_EN
    assign tx_start = (state_q == ST_SEND) || (state_q == ST_HDR_SEND);
    assign tx_data  = ((state_q == ST_HDR_SEND) || (state_q == ST_HDR_WAIT))
                      ? {HDR_TAG, 4'(grant_q)} : hold_q;
`else
    assign tx_start = (state_q == ST_SEND);
    assign tx_data  = hold_q;
`endif

    assign grant_id    = grant_q;
    assign active      = (state_q != ST_ARB);
    assign err_timeout = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N  = 4;
    localparam int TO = 4096;

    // ---------------- clock / reset / DUT ----------------
    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           active;
    logic           err_timeout;
    arb_state_e     dbg_state;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .err_timeout (err_timeout),
        .dbg_state   (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Round-robin rule: first valid requester after 'last', wrapping.
    function automatic int rr_pick(int last, logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return 255;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    int tx_st;
    int tx_cnt;

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        tx_st     = 0;
        tx_cnt    = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Transmitter model: acks a held tx_start after 0..3 cycles, stays busy 1..4 cycles.
    task automatic tx_tick(input logic saw_start);
        case (tx_st)
            0: if (saw_start) begin
                tx_cnt = $urandom_range(0, 3);
                if (tx_cnt == 0) begin
                    tx_busy = 1'b1;
                    tx_cnt  = $urandom_range(1, 4);
                    tx_st   = 2;
                end else begin
                    tx_st = 1;
                end
            end
            1: begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_busy = 1'b1;
                    tx_cnt  = $urandom_range(1, 4);
                    tx_st   = 2;
                end
            end
            default: begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_busy = 1'b0;
                    tx_st   = 0;
                end
            end
        endcase
    endtask

    task automatic wait_start(input string tag);
        int k = 0;
        while (tx_start !== 1'b1 && k < 20) begin
            sample();
            k++;
        end
        check({tag, "_start_seen"}, 32'(tx_start), 32'd1);
    endtask

    // Manually serves one frame: check byte, hold, ack, drop, finish.
    task automatic serve_frame(input logic [7:0] exp_b, input string tag);
        wait_start(tag);
        check({tag, "_data"}, 32'(tx_data), 32'(exp_b));
        repeat (3) begin
            sample();
            check({tag, "_start_hold"}, 32'(tx_start), 32'd1);
            check({tag, "_no_ready"}, 32'(req_ready), 32'd0);
        end
        step();
        tx_busy = 1'b1;
        sample();
        check({tag, "_start_until_ack"}, 32'(tx_start), 32'd1);
        sample();
        check({tag, "_start_drop"}, 32'(tx_start), 32'd0);
        check({tag, "_active_busy"}, 32'(active), 32'd1);
        step();
        tx_busy = 1'b0;
        sample();
        check({tag, "_active_wait"}, 32'(active), 32'd1);
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [7:0] exp_q[$];
    bit         mon_en = 1'b0;

    initial begin : monitor
        int mdl_last;
        int frames_left;
        int gid_exp;
        int w;
        bit prev_busy;
        bit expect_arb;
        bit gid_pend;
        bit chk_drop;
        forever begin
            @(negedge clk);
            if (!mon_en || rst !== 1'b1) begin
                mdl_last    = N - 1;
                frames_left = 0;
                prev_busy   = 1'b0;
                expect_arb  = 1'b0;
                gid_pend    = 1'b0;
                chk_drop    = 1'b0;
                exp_q.delete();
            end else begin
                if (expect_arb) begin
                    check("mon_arb_active", 32'(active), 32'd0);
                    check("mon_arb_gap", 32'(req_ready != '0), 32'(req_valid != '0));
                    check("mon_no_err", 32'(err_timeout), 32'd0);
                    expect_arb = 1'b0;
                end
                if (gid_pend) begin
                    check("mon_grant_id", 32'(grant_id), 32'(gid_exp));
                    gid_pend = 1'b0;
                end
                if (chk_drop) begin
                    check("mon_start_drop", 32'(tx_start), 32'd0);
                    chk_drop = 1'b0;
                end
                if (req_ready != '0) begin
                    check("mon_accept_idle", 32'(frames_left), 32'd0);
                    w = rr_pick(mdl_last, req_valid);
                    if (w < 0) begin
                        check("mon_ready_no_valid", 32'(req_ready), 32'd0);
                    end else begin
                        check("mon_rr_grant", 32'(req_ready), 32'd1 << w);
                        mdl_last = w;
                        gid_exp  = w;
                        gid_pend = 1'b1;
`ifdef UART_ARB_HDR_EN
                        exp_q.push_back({HDR_TAG, 4'(w)});
                        frames_left++;
`endif
                        exp_q.push_back(req_data[8*w +: 8]);
                        frames_left++;
                    end
                end
                if (!prev_busy && tx_busy) begin
                    check("mon_start_at_ack", 32'(tx_start), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("mon_unexpected_frame", 32'(tx_data), 32'hFFFF_FFFF);
                    end else begin
                        check("mon_tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                    end
                    chk_drop = 1'b1;
                end
                if (prev_busy && !tx_busy) begin
                    frames_left--;
                    if (frames_left == 0) expect_arb = 1'b1;
                end
                prev_busy = tx_busy;
            end
        end
    end

    // ---------------- main stimulus ----------------
    initial begin : main
        logic [N-1:0] fire;
        logic         txs;
        logic         prev;
        int           got_g[5];
        logic [7:0]   got_b[5];
        logic [7:0]   exp_b[10];
        int           ng;
        int           nb;
        int           cnt;
        bit           seen;
        bit           drained;

        // Reset values, with all requesters valid to exercise the ready mask.
        rst       = 1'b0;
        tx_busy   = 1'b0;
        req_valid = '1;
        req_data  = 32'h4433_2211;
        sample();
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);

        // Single requester.
        do_reset();
        req_valid[2]         = 1'b1;
        req_data[23:16]      = 8'h5A;
        sample();
        check("single_ready", 32'(req_ready), 32'b0100);
        check("single_arb_active", 32'(active), 32'd0);
        step();
        req_valid = '0;
        sample();
        check("single_latency", 32'(tx_start), 32'd1);
        check("single_grant_id", 32'(grant_id), 32'd2);
        check("single_active", 32'(active), 32'd1);
`ifdef UART_ARB_HDR_EN
        serve_frame(8'hA2, "single_hdr");
`endif
        serve_frame(8'h5A, "single");
        step();
        sample();
        check("single_idle_active", 32'(active), 32'd0);
        check("single_idle_start", 32'(tx_start), 32'd0);

        // Fairness: all four continuously valid.
        do_reset();
        req_valid = '1;
        req_data  = 32'h1312_1110;
        for (int k = 0; k < 5; k++) begin
            got_g[k] = 255;
            got_b[k] = 8'hFF;
        end
        nb = 0;
        for (int g = 0; g < 5; g++) begin
`ifdef UART_ARB_HDR_EN
            exp_b[nb] = {HDR_TAG, 4'(g % N)};
            nb++;
`endif
            exp_b[nb] = 8'h10 + 8'(g % N);
            nb++;
        end
        ng   = 0;
        nb   = 0;
        prev = 1'b0;
        for (int c = 0; c < 600 && (ng < 5 || nb < 5); c++) begin
            sample();
            if (req_ready != '0 && ng < 5) begin
                got_g[ng] = onehot_idx(req_ready);
                ng++;
            end
            if (!prev && tx_busy && nb < 5) begin
                got_b[nb] = tx_data;
                nb++;
            end
            prev = tx_busy;
            txs  = tx_start;
            step();
            tx_tick(txs);
        end
        for (int k = 0; k < 5; k++) begin
            check($sformatf("fair_grant%0d", k), 32'(got_g[k]), 32'(k % N));
            check($sformatf("fair_byte%0d", k), 32'(got_b[k]), 32'(exp_b[k]));
        end

        // Ack timeout.
        do_reset();
        req_valid[1]    = 1'b1;
        req_data[15:8]  = 8'h77;
        sample();
        check("to_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid      = 4'b0101;
        req_data[7:0]  = 8'h01;
        req_data[23:16] = 8'h22;
        cnt  = 0;
        seen = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            sample();
            if (err_timeout === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (tx_start === 1'b1) cnt++;
        end
        check("to_err_seen", 32'(seen), 32'd1);
        check("to_send_cycles", 32'(cnt), 32'(TO));
        check("to_next_winner", 32'(req_ready), 32'b0100);
        check("to_arb_active", 32'(active), 32'd0);
        check("to_start_low", 32'(tx_start), 32'd0);
        step();
        req_valid = '0;
        sample();
        check("to_err_pulse", 32'(err_timeout), 32'd0);
        check("to_grant_id", 32'(grant_id), 32'd2);

`ifdef UART_ARB_HDR_EN
        // Header framing.
        do_reset();
        req_valid[3]    = 1'b1;
        req_data[31:24] = 8'hC3;
        sample();
        check("hdr_ready", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        serve_frame(8'hA3, "hdr_h");
        serve_frame(8'hC3, "hdr_p");
`endif

        // Reset in the middle of a send.
        do_reset();
        req_valid[3]    = 1'b1;
        req_data[31:24] = 8'h33;
        sample();
        check("mid_ready", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'b0111;
        req_data[23:0] = 24'h22_11_00;
        sample();
        check("mid_start", 32'(tx_start), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_start", 32'(tx_start), 32'd0);
        check("mid_rst_data", 32'(tx_data), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_active", 32'(active), 32'd0);
        check("mid_rst_err", 32'(err_timeout), 32'd0);
        check("mid_rst_grant", 32'(grant_id), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        sample();
        check("mid_first_winner", 32'(req_ready), 32'b0001);

        // Late drop while the FSM is waiting for the frame to finish.
        do_reset();
        req_valid[3]    = 1'b1;
        req_data[31:24] = 8'h3C;
        sample();
        check("late_ready3", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
`ifdef UART_ARB_HDR_EN
        serve_frame(8'hA3, "late_h");
`endif
        wait_start("late");
        step();
        tx_busy = 1'b1;
        step();
        req_valid[0]  = 1'b1;
        req_data[7:0] = 8'h0F;
        sample();
        check("late_wait_ready", 32'(req_ready), 32'd0);
        step();
        req_valid[0]    = 1'b0;
        req_valid[1]    = 1'b1;
        req_data[15:8]  = 8'h1E;
        step();
        tx_busy = 1'b0;
        sample();
        check("late_still_wait", 32'(req_ready), 32'd0);
        step();
        sample();
        check("late_only_req1", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        sample();
        check("late_grant_id", 32'(grant_id), 32'd1);

        // Randomized traffic against the scoreboard.
        do_reset();
        mon_en  = 1'b1;
        drained = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sample();
            fire = req_valid & req_ready;
            txs  = tx_start;
            step();
            for (int i = 0; i < N; i++) begin
                if (fire[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && cyc < 2400 && $urandom_range(0, 3) == 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
            tx_tick(txs);
            if (cyc >= 2400 && req_valid == '0 && tx_st == 0 && active === 1'b0) begin
                drained = 1'b1;
                break;
            end
        end
        repeat (3) sample();
        check("rand_drained", 32'(drained), 32'd1);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares a single UART transmitter among `N_REQ` byte-stream requesters. It accepts one byte at a time from the winning requester over a valid/ready handshake. It then drives the transmitter's `t_start`/`data_in` pair and tracks its `t_busy` output until the frame completes. It sits between the client blocks (command responders, debug streams) and the UART TX instance.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `ACK_TIMEOUT`, default 4096: clk cycles to wait for `tx_busy` to rise after `tx_start` before aborting; 16-bit.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester byte available.
- `req_data`  in  8*N_REQ  flat byte bus; requester i on bits [8i+7:8i].
- `req_ready`  out  N_REQ  one-hot; high in the cycle the byte of requester i is accepted.
- `tx_data`  out  8  byte to the transmitter's `data_in`.
- `tx_start`  out  1  transmit request to the transmitter's `t_start`.
- `tx_busy`  in  1  transmitter's `t_busy`.
- `grant_id`  out  clog2(N_REQ)  index of the current or last granted requester.
- `active`  out  1  high whenever the FSM is not in ARB.
- `err_timeout`  out  1  one-cycle pulse when a byte is dropped on ack timeout.

## Operation
- **FSM states:** ARB, SEND, WAIT_DONE, plus HDR_SEND and HDR_WAIT when `UART_ARB_HDR_EN` is defined.
- **ARB state:**
  - The search starts at `last+1` mod `N_REQ` and picks the first requester with `req_valid` set.
  - `req_ready[winner]` is asserted combinationally in the same cycle. The byte is captured into the hold register at that edge.
  - `last` and `grant_id` are updated to the winner.
  - The FSM goes to SEND, or to HDR_SEND when the header feature is enabled.
  - With no valid requester, the FSM stays in ARB and all `req_ready` outputs are 0.
- **SEND state:**
  - `tx_start`=1 and `tx_data` = the held byte.
  - The FSM stays here until `tx_busy`=1, then goes to WAIT_DONE with `tx_start` dropped on that edge.
  - The timeout counter increments each cycle while in SEND. If it reaches `ACK_TIMEOUT`, the byte is discarded, `err_timeout` pulses, and the FSM returns to ARB.
- **WAIT_DONE state:** `tx_start`=0. The FSM waits for `tx_busy`=0, then returns to ARB. There is no timeout in this state.
- **Requester rule:** a requester must hold `req_valid` and `req_data` stable until it sees `req_ready`. If it drops `req_valid` before grant, nothing is accepted.
- **Round-robin fairness:** a continuously valid requester is served at least once every `N_REQ` grants. After a timeout, `last` still points at the dropped requester, so rotation continues past it.
- **Reset, including mid-frame:**
  - `tx_start`=0, `tx_data`=0, `req_ready`=0, `active`=0, `err_timeout`=0, `grant_id`=0.
  - `last`=N_REQ-1, so requester 0 wins first. FSM = ARB, timeout counter = 0.
  - A transmitter frame in flight is not aborted by this block.

## Timing
- Acceptance edge to `tx_start` high: 1 cycle.
- `tx_start` remains high across any number of cycles until `tx_busy` is sampled high. The transmitter samples `t_start` only on baud ticks, so the hold is mandatory.
- `tx_busy` falling to the next acceptance: 1 cycle (the ARB cycle). When a requester is valid, back-to-back frames have a 1-cycle gap before `tx_start` is raised again.
- `err_timeout` is asserted for exactly the one cycle after the counter hits `ACK_TIMEOUT`. The counter clears on every entry to SEND or HDR_SEND.
- `tx_busy` already high on entry to SEND is treated as an immediate ack: SEND lasts 1 cycle.

## Configuration
- **`UART_ARB_HDR_EN` defined:**
  - Each accepted byte is preceded by a header byte `{4'hA, grant_id}` zero-extended to 4 bits.
  - The header runs through HDR_SEND and HDR_WAIT, which follow the same rules as SEND and WAIT_DONE, including the timeout.
  - The FSM then goes to SEND for the payload. A header timeout drops both the header and the payload.
- **`UART_ARB_HDR_EN` undefined:** payload bytes only; the HDR states are absent.

## Structure
- **Package `uart_arb_pkg`:** FSM state encoding, `HDR_TAG`=4'hA, default `ACK_TIMEOUT`.
- **Sub-module `uart_rr_picker`:** combinational round-robin picker. Inputs are `req_valid` and `last`; outputs are a one-hot grant and an `any` flag. It is reused by other shared-resource arbiters.

## Test plan
- **Single requester, no header:** reset, then `req_valid[2]`=1 with `req_data[23:16]`=8'h5A. Required: `req_ready`=4'b0100 for one cycle, then `tx_data`=8'h5A with `tx_start` held until the model raises `tx_busy`. `tx_start`=0 after `tx_busy` rises, and `active`=0 after `tx_busy` falls.
- **Fairness:** all four requesters continuously valid with bytes 8'h10..8'h13. Required grant order is 0,1,2,3,0 and the transmitted byte sequence is 10,11,12,13,10.
- **Timeout:** `tx_busy` is held at 0 and `req_valid[1]` is set. Required: `err_timeout` pulses once after exactly 4096 SEND cycles, the FSM returns to ARB, and requester 2 wins next if valid.
- **Header (`UART_ARB_HDR_EN`):** requester 3 sends 8'hC3. Required transmitter bytes are 8'hA3 then 8'hC3, with a single `req_ready` pulse.
- **Reset mid-SEND:** assert `rst`=0 while `tx_start`=1. Required: all outputs go to their reset values immediately, and requester 0 wins first after release.
- **Late drop:** `req_valid[0]` is deasserted in the same cycle requester 1 becomes valid, while the FSM is in WAIT_DONE. Required: only requester 1 is accepted.
